// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - N-to-1 round-robin gather mux with a registered valid/ready output
// A rotating priority pointer picks one valid source per cycle and loads it into the output register.
module rr_mux_arbiter #(
    parameter int select_bit = 1,
    parameter int data_bits  = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [(2**select_bit)*data_bits-1:0]   data_bus,
    input  logic [(2**select_bit)-1:0]             in_valid,
    output logic [(2**select_bit)-1:0]             in_ready,
    output logic [data_bits-1:0]                   out,
    output logic [select_bit-1:0]                  out_sel,
    output logic                                   out_valid,
    input  logic                                   out_ready
);
    localparam int N = 2**select_bit;

    logic [select_bit-1:0] rr_ptr_q, rr_ptr_d;
    logic [data_bits-1:0]  out_q, out_d;
    logic [select_bit-1:0] out_sel_q, out_sel_d;
    logic                  out_valid_q, out_valid_d;

    logic [select_bit-1:0] grant;
    logic [select_bit-1:0] idx;
    logic                  has_grant;
    logic                  load;

    assign load      = ~out_valid_q | out_ready;
    assign has_grant = |in_valid;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = rr_ptr_q + select_bit'(k);
            if (in_valid[idx]) begin
                grant = idx;
            end
        end
    end

    // Reset gates the handshake so no source sees a spurious accept.
    always_comb begin
        in_ready = '0;
        if (load && has_grant && !rst) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (load) begin
            if (has_grant) begin
                out_d       = data_bus[grant*data_bits +: data_bits];
                out_sel_d   = grant;
                out_valid_d = 1'b1;
                rr_ptr_d    = grant + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            out_q       <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
endmodule
